// File: rtl/branch_resolve.sv
// ============================================================================
// Module   : branch_resolve
// Purpose  : Multi-cycle branch resolver: compare, decide, target, flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        br_valid_i,
  output logic        br_ready_o,
  input  logic [2:0]  br_op_i,
  input  logic [31:0] br_a_i,
  input  logic [31:0] br_b_i,
  input  logic [31:0] br_pc_i,
  input  logic [16:0] br_imm_i,
  output logic        comp_enable_o,
  output logic [31:0] comp_a_o,
  output logic [31:0] comp_b_o,
  input  logic        comp_eq_i,
  input  logic        comp_gt_i,
  output logic        res_valid_o,
  output logic        res_taken_o,
  output logic [31:0] res_target_o,
  output logic        flush_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMP   = 2'd1,
    S_RES   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  localparam logic [2:0] C_FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, pc_q, target_q;
  logic [16:0] imm_q;
  logic        eq_q, gt_q;
  logic        w_accept;
  logic        w_taken;

  // Direction from the flags captured during CMP.
  always_comb begin
    w_taken = 1'b0;
    case (op_q)
      3'd0:    w_taken = !eq_q;
      3'd1:    w_taken = !eq_q && !gt_q;
      3'd2:    w_taken = gt_q;
      3'd3:    w_taken = eq_q;
      3'd4:    w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    w_accept      = 1'b0;
    br_ready_o    = 1'b0;
    comp_enable_o = 1'b0;
    comp_a_o      = 32'd0;
    comp_b_o      = 32'd0;
    res_valid_o   = 1'b0;
    flush_o       = 1'b0;
    case (state_q)
      S_IDLE: begin
        br_ready_o = !reset_i;
        if (br_valid_i && !reset_i) begin
          w_accept = 1'b1;
          state_d  = S_CMP;
        end
      end
      S_CMP: begin
        comp_enable_o = 1'b1;
        comp_a_o      = a_q;
        comp_b_o      = b_q;
        state_d       = S_RES;
      end
      S_RES: begin
        res_valid_o = 1'b1;
        state_d     = S_IDLE;
        if (w_taken) begin
          flush_o = 1'b1;
          cnt_d   = C_FLUSH_LOAD;
          if (FLUSH_CYCLES > 1) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        flush_o = 1'b1;
        cnt_d   = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign res_taken_o  = (state_q == S_RES) && w_taken;
  assign res_target_o = target_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      op_q     <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      pc_q     <= 32'd0;
      imm_q    <= 17'd0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      target_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_accept) begin
        op_q  <= br_op_i;
        a_q   <= br_a_i;
        b_q   <= br_b_i;
        pc_q  <= br_pc_i;
        imm_q <= br_imm_i;
      end
      // Comparator is combinational; flags are only trusted in CMP.
      if (state_q == S_CMP) begin
        eq_q     <= comp_eq_i;
        gt_q     <= comp_gt_i;
        target_q <= pc_q + {{15{imm_q[16]}}, imm_q};
      end
    end
  end

endmodule

`default_nettype wire
